fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 50 +++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and round-robin search helper for the FIFO write/read schedulers.
// Latency: none (types and a pure combinational function).
// Backpressure: n/a.
//
// Contents:
//   arb_state_e  - burst arbiter FSM states (IDLE, BURST)
//   rr_pick_t    - result of a rotate-priority search (found flag + index)
//   rr_pick()    - search req starting one past 'last', wrapping at n
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Widest requester vector the shared search supports.
   localparam int RR_MAX_N = 32;
   localparam int RR_IDX_W = 5;
   localparam int RR_CNT_W = RR_IDX_W + 1;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // Rotate-priority search: first set bit of req[0..n-1] at or after
   // (last+1) mod n. 'last' must be < n. The loop is fully unrolled; the
   // wrap is a single conditional subtract because last+i < 2n.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                        input logic [RR_IDX_W-1:0] last,
                                        input logic [RR_CNT_W-1:0] n);
      rr_pick_t            res;
      logic [RR_CNT_W-1:0] k;
      logic [RR_CNT_W-1:0] step;
      res = '0;
      for (int i = 1; i <= RR_MAX_N; i++) begin
         step = RR_CNT_W'(i);
         k    = {1'b0, last} + step;
         if (k >= n) begin
            k = k - n;
         end
         if ((step <= n) && !res.found && req[k[RR_IDX_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = k[RR_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: picks the first requester after last_i.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the pick.
//
// Ports:
//   req_i     [N]   request vector
//   last_i    [IW]  index of the previous winner (lowest priority this round)
//   gnt_oh_o  [N]   one-hot winner, all zero when no request
//   gnt_idx_o [IW]  binary winner index (valid when found_o)
//   found_o         at least one request present
module rr_arbiter import fifo_arb_pkg::*; #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_oh_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          found_o
);

   // N must not exceed RR_MAX_N; the shared search is sized for that.
   rr_pick_t pick;

   always_comb begin
      pick = rr_pick(RR_MAX_N'(req_i), RR_IDX_W'(last_i), RR_CNT_W'(N));
   end

   assign found_o   = pick.found;
   assign gnt_idx_o = pick.idx[IW-1:0];

   always_comb begin
      gnt_oh_o = '0;
      for (int i = 0; i < N; i++) begin
         gnt_oh_o[i] = pick.found && (pick.idx == RR_IDX_W'(i));
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N requesters.
// Latency: request seen in IDLE -> grant and first beat next cycle; one idle bubble between bursts.
// Backpressure: req_ready of the granted requester follows !fifo_full; beats never presented while full.
//
// Ports:
//   clk, rst_n            write-domain clock, async active-low reset
//   req_valid/last [N]    per-requester beat valid and end-of-burst marker
//   req_data [N*DW]       requester i on bits [i*DW +: DW]
//   req_ready [N]         beat accept, only ever set for the granted requester
//   fifo_w_en, fifo_w_data  FIFO write port (data is 0 when not writing)
//   fifo_full             registered full flag from the FIFO
//   grant_id [IW]         current / most recent grant
//   busy                  high while a burst is granted
//   trunc_pulse           one cycle after a burst is cut at MAX_BURST without last
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
   parameter  int N         = 4,
   parameter  int DW        = 8,
   parameter  int MAX_BURST = 16,
   localparam int IW        = (N > 1) ? $clog2(N) : 1,
   localparam int BW        = $clog2(MAX_BURST + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_valid,
   input  logic [N*DW-1:0] req_data,
   input  logic [N-1:0]    req_last,
   output logic [N-1:0]    req_ready,
   output logic            fifo_w_en,
   output logic [DW-1:0]   fifo_w_data,
   input  logic            fifo_full,
   output logic [IW-1:0]   grant_id,
   output logic            busy,
   output logic            trunc_pulse
);

   arb_state_e    state_q,  state_d;
   logic [IW-1:0] grant_q,  grant_d;
   logic [N-1:0]  gnt_oh_q, gnt_oh_d;
   logic [BW-1:0] cnt_q,    cnt_d;
   logic          trunc_q,  trunc_d;

   logic [N-1:0]  pick_oh;
   logic [IW-1:0] pick_idx;
   logic          pick_found;

   logic          g_valid;
   logic          g_last;
   logic [DW-1:0] g_data;
   logic          accept;
   logic [BW-1:0] cnt_inc;

   // The previous grant is the search origin, so the requester that just
   // finished automatically has the lowest priority.
   rr_arbiter #(.N(N)) u_rr (
      .req_i     (req_valid),
      .last_i    (grant_q),
      .gnt_oh_o  (pick_oh),
      .gnt_idx_o (pick_idx),
      .found_o   (pick_found)
   );

   assign g_valid = |(req_valid & gnt_oh_q);
   assign g_last  = |(req_last  & gnt_oh_q);
   assign g_data  = req_data[grant_q*DW +: DW];
   assign cnt_inc = cnt_q + BW'(1);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gnt_oh_d    = gnt_oh_q;
      cnt_d       = cnt_q;
      trunc_d     = 1'b0;
      accept      = 1'b0;
      req_ready   = '0;
      fifo_w_en   = 1'b0;
      fifo_w_data = '0;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d  = pick_idx;
               gnt_oh_d = pick_oh;
               cnt_d    = '0;
               state_d  = BURST;
            end
         end
         BURST: begin
            // Ready is offered regardless of valid; only full gates it.
            req_ready = fifo_full ? '0 : gnt_oh_q;
            accept    = g_valid && !fifo_full;
            if (accept) begin
               fifo_w_en   = 1'b1;
               fifo_w_data = g_data;
               cnt_d       = cnt_inc;
               // last wins over the cap, so a coinciding cap is a normal exit
               if (g_last) begin
                  state_d = IDLE;
               end else if (cnt_inc == BW'(MAX_BURST)) begin
                  state_d = IDLE;
                  trunc_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= IW'(N - 1);
         gnt_oh_q <= {1'b1, {(N-1){1'b0}}};
         cnt_q    <= '0;
         trunc_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gnt_oh_q <= gnt_oh_d;
         cnt_q    <= cnt_d;
         trunc_q  <= trunc_d;
      end
   end

   assign busy        = (state_q == BURST);
   assign grant_id    = grant_q;
   assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed burst scenarios plus randomized traffic vs. a burst-level model.
// Latency: n/a (testbench).
// Backpressure: a bench FIFO of depth 8 drives a registered full flag; reader rate is scenario-controlled.
module tb_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int MAXB  = 4;
   localparam int DEPTH = 8;
   localparam int IW    = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            fifo_w_en;
   logic [DW-1:0]   fifo_w_data;
   logic            fifo_full;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic            trunc_pulse;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MAXB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .fifo_w_en   (fifo_w_en),
      .fifo_w_data (fifo_w_data),
      .fifo_full   (fifo_full),
      .grant_id    (grant_id),
      .busy        (busy),
      .trunc_pulse (trunc_pulse)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pending beats per requester (head is what is being offered).
   logic [DW-1:0] q_dat [N][$];
   bit            q_lst [N][$];

   int gate_pct = 100;  // chance a non-empty requester shows valid
   int rd_mode  = 0;    // 0 stalled, 1 every cycle, 2 random
   int fifo_cnt = 0;
   int cyc      = 0;

   // Burst-level reference: who owns the port and how many beats it has used.
   bit m_busy;
   int m_gid;
   int m_cnt;
   bit m_trunc;

   // Observations of the DUT for the directed scenarios.
   int            grant_log [$];
   logic [DW-1:0] wlog [$];
   int            wcyc [$];
   int            n_wr;
   int            n_trunc;
   bit            prev_busy;

   function automatic int gl(input int i);
      return (i < grant_log.size()) ? grant_log[i] : -1;
   endfunction
   function automatic int wl(input int i);
      return (i < wlog.size()) ? int'(wlog[i]) : -1;
   endfunction
   function automatic int wc(input int i);
      return (i < wcyc.size()) ? wcyc[i] : -1;
   endfunction
   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int i = 0; i < N; i++) if (q_dat[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (q_dat[i].size() != 0) begin
            req_valid[i]           = ($urandom_range(99) < gate_pct);
            req_data[i*DW +: DW]   = q_dat[i][0];
            req_last[i]            = q_lst[i][0];
         end else begin
            req_valid[i]           = 1'b0;
            req_data[i*DW +: DW]   = '0;
            req_last[i]            = 1'b0;
         end
      end
   endtask

   task automatic push(input int r, input logic [DW-1:0] d, input bit l);
      q_dat[r].push_back(d);
      q_lst[r].push_back(l);
   endtask

   task automatic clear_obs();
      grant_log.delete();
      wlog.delete();
      wcyc.delete();
      n_wr    = 0;
      n_trunc = 0;
   endtask

   task automatic reset_model();
      m_busy    = 1'b0;
      m_gid     = N - 1;
      m_cnt     = 0;
      m_trunc   = 1'b0;
      prev_busy = 1'b0;
   endtask

   // One clock: compare at negedge, advance the model, apply edge effects at posedge+1.
   task automatic cycle();
      bit            exp_wen;
      bit            rd;
      logic [N-1:0]  exp_rdy;
      logic [DW-1:0] exp_dat;
      int            g;
      @(negedge clk);
      g       = m_gid;
      exp_wen = m_busy && req_valid[g] && !fifo_full;
      exp_rdy = (m_busy && !fifo_full) ? (N'(1) << g) : '0;
      exp_dat = exp_wen ? q_dat[g][0] : '0;
      check_eq("busy",   32'(busy),        32'(m_busy));
      check_eq("gid",    32'(grant_id),    m_gid);
      check_eq("trunc",  32'(trunc_pulse), 32'(m_trunc));
      check_eq("ready",  32'(req_ready),   32'(exp_rdy));
      check_eq("w_en",   32'(fifo_w_en),   32'(exp_wen));
      check_eq("w_data", 32'(fifo_w_data), 32'(exp_dat));

      if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
      prev_busy = busy;
      if (fifo_w_en) begin
         n_wr++;
         wlog.push_back(fifo_w_data);
         wcyc.push_back(cyc);
      end
      if (trunc_pulse) n_trunc++;

      m_trunc = 1'b0;
      if (!m_busy) begin
         for (int j = 1; j <= N; j++) begin
            int k;
            k = (m_gid + j) % N;
            if (!m_busy && req_valid[k]) begin
               m_gid  = k;
               m_busy = 1'b1;
               m_cnt  = 0;
            end
         end
      end else if (exp_wen) begin
         m_cnt++;
         if (q_lst[g][0]) begin
            m_busy = 1'b0;
         end else if (m_cnt == MAXB) begin
            m_busy  = 1'b0;
            m_trunc = 1'b1;
         end
      end
      rd = (rd_mode == 1 || (rd_mode == 2 && $urandom_range(1) == 1)) && (fifo_cnt > 0);

      @(posedge clk);
      #1;
      if (exp_wen) begin
         void'(q_dat[g].pop_front());
         void'(q_lst[g].pop_front());
         fifo_cnt++;
      end
      if (rd) fifo_cnt--;
      fifo_full = (fifo_cnt >= DEPTH);
      cyc++;
      drive();
   endtask

   task automatic run_idle(input int budget, input string tag);
      int n;
      n = 0;
      while (!(all_empty() && !m_busy) && n < budget) begin
         cycle();
         n++;
      end
      check_eq(tag, 32'(all_empty() && !m_busy), 32'd1);
      cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"},  32'(busy),        32'd0);
      check_eq({tag, "_ready"}, 32'(req_ready),   32'd0);
      check_eq({tag, "_gid"},   32'(grant_id),    N - 1);
      check_eq({tag, "_wen"},   32'(fifo_w_en),   32'd0);
      check_eq({tag, "_wdat"},  32'(fifo_w_data), 32'd0);
      check_eq({tag, "_trunc"}, 32'(trunc_pulse), 32'd0);
   endtask

   // Entered at posedge+1; FIFO shares the reset so it starts empty.
   task automatic do_reset();
      rst_n = 1'b0;
      reset_model();
      fifo_cnt  = 0;
      fifo_full = 1'b0;
      #2;
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_obs();
      drive();
   endtask

   initial begin
      int t0;
      int total;
      int len;
      int n;
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      reset_model();
      clear_obs();
      @(posedge clk);
      #1;
      do_reset();

      // Single 3-beat burst from requester 2.
      rd_mode = 1;
      push(2, 8'hA1, 1'b0);
      push(2, 8'hA2, 1'b0);
      push(2, 8'hA3, 1'b1);
      drive();
      t0 = cyc;
      run_idle(50, "t1_done");
      check_eq("t1_nwr",  n_wr,  3);
      check_eq("t1_gnt",  gl(0), 2);
      check_eq("t1_d0",   wl(0), 32'hA1);
      check_eq("t1_d1",   wl(1), 32'hA2);
      check_eq("t1_d2",   wl(2), 32'hA3);
      check_eq("t1_c0",   wc(0), t0 + 1);
      check_eq("t1_c2",   wc(2), t0 + 3);

      // Everyone sends single-beat bursts: strict rotation, two cycles each.
      do_reset();
      for (int rep = 0; rep < 2; rep++)
         for (int i = 0; i < N; i++) push(i, DW'(16 * i + rep), 1'b1);
      drive();
      run_idle(100, "t2_done");
      check_eq("t2_ngnt", grant_log.size(), 8);
      check_eq("t2_g0", gl(0), 0);
      check_eq("t2_g1", gl(1), 1);
      check_eq("t2_g2", gl(2), 2);
      check_eq("t2_g3", gl(3), 3);
      check_eq("t2_g4", gl(4), 0);
      check_eq("t2_span", wc(4) - wc(0), 8);
      check_eq("t2_d4", wl(4), 32'h01);

      // Stalled reader, 10 beats: exactly DEPTH writes then hold while full.
      do_reset();
      rd_mode = 0;
      for (int i = 0; i < 10; i++) push(0, DW'(8'h10 + i), i == 9);
      drive();
      repeat (40) cycle();
      check_eq("t3_nwr",   n_wr, 8);
      check_eq("t3_ntr",   n_trunc, 2);
      check_eq("t3_busy",  32'(busy), 32'd1);
      check_eq("t3_gid",   32'(grant_id), 32'd0);
      check_eq("t3_ready", 32'(req_ready), 32'd0);
      check_eq("t3_wen",   32'(fifo_w_en), 32'd0);
      rd_mode = 1;
      cycle();
      cycle();
      rd_mode = 0;
      run_idle(50, "t3_done");
      check_eq("t3_nwr2", n_wr, 10);
      check_eq("t3_d8",   wl(8), 32'h18);
      check_eq("t3_d9",   wl(9), 32'h19);

      // Burst cut at MAX_BURST while requester 3 waits.
      do_reset();
      rd_mode = 1;
      for (int i = 0; i < 6; i++) push(1, DW'(8'h30 + i), i == 5);
      push(3, 8'h3F, 1'b1);
      drive();
      run_idle(100, "t4_done");
      check_eq("t4_ngnt", grant_log.size(), 3);
      check_eq("t4_g0", gl(0), 1);
      check_eq("t4_g1", gl(1), 3);
      check_eq("t4_g2", gl(2), 1);
      check_eq("t4_ntr", n_trunc, 1);
      check_eq("t4_nwr", n_wr, 7);
      check_eq("t4_d3", wl(3), 32'h33);
      check_eq("t4_d4", wl(4), 32'h3F);
      check_eq("t4_d6", wl(6), 32'h35);

      // last on the capping beat is a normal exit.
      do_reset();
      for (int i = 0; i < 4; i++) push(0, DW'(8'h50 + i), i == 3);
      drive();
      run_idle(50, "t5_done");
      check_eq("t5_ntr",  n_trunc, 0);
      check_eq("t5_nwr",  n_wr, 4);
      check_eq("t5_ngnt", grant_log.size(), 1);

      // Reset mid-burst after two beats.
      do_reset();
      for (int i = 0; i < 4; i++) push(2, DW'(8'h60 + i), i == 3);
      drive();
      n = 0;
      while (n_wr < 2 && n < 50) begin
         cycle();
         n++;
      end
      check_eq("t6_pre", n_wr, 2);
      push(0, 8'h6A, 1'b1);
      drive();
      rst_n = 1'b0;
      #2;
      check_reset_outputs("t6");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_model();
      clear_obs();
      drive();
      run_idle(100, "t6_done");
      check_eq("t6_g0",  gl(0), 0);
      check_eq("t6_g1",  gl(1), 2);
      check_eq("t6_d0",  wl(0), 32'h6A);
      check_eq("t6_d1",  wl(1), 32'h62);
      check_eq("t6_nwr", n_wr, 3);

      // Randomized traffic: gapped valids, random reader, random burst lengths.
      do_reset();
      gate_pct = 70;
      rd_mode  = 2;
      total    = 0;
      for (int i = 0; i < N; i++) begin
         for (int b = 0; b < 8; b++) begin
            len = int'($urandom_range(7, 1));
            for (int j = 0; j < len; j++) push(i, DW'($urandom), j == len - 1);
            total += len;
         end
      end
      drive();
      run_idle(6000, "t7_done");
      check_eq("t7_nwr", n_wr, total);
      gate_pct = 100;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
